// File: rtl/tlfs_pkg.sv
// Shared types for the four-lane phase scheduler.
// State encoding, lane geometry and lane one-hot helper.
package tlfs_pkg;

  typedef enum logic [1:0] {
    ALLRED,
    GREEN,
    YELLOW,
    EMG_GREEN
  } state_t;

  localparam int LANES = 4;
  localparam int LW = 2;

  function automatic logic [LANES-1:0] lane_onehot(
    input logic [LW-1:0] l
  );
    logic [LANES-1:0] r;
    r = '0;
    r[l] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/lane_phase_scheduler_if.sv
// Bundle between car counters, scheduler and light drivers.
// Master drives requests and time base; slave drives the lights.
interface lane_phase_scheduler_if #(
  parameter int CNT_W = 4
);
  import tlfs_pkg::*;

  logic             en;
  logic             tick;
  logic [CNT_W-1:0] cur1;
  logic [CNT_W-1:0] cur2;
  logic [CNT_W-1:0] cur3;
  logic [CNT_W-1:0] cur4;
  logic [LANES-1:0] emg;
  logic [LANES-1:0] green;
  logic [LANES-1:0] yellow;
  logic [LANES-1:0] red;
  logic [LW-1:0]    lane;
  logic             preempt;

  modport master (
    output en, tick, cur1, cur2, cur3, cur4, emg,
    input  green, yellow, red, lane, preempt
  );

  modport slave (
    input  en, tick, cur1, cur2, cur3, cur4, emg,
    output green, yellow, red, lane, preempt
  );

endinterface

// File: rtl/lane_phase_scheduler_rr_lane_pick.sv
// Round-robin picker: first requesting lane at or after ptr,
// wrapping 3->0.
module rr_lane_pick
  import tlfs_pkg::*;
(
  input  logic [LW-1:0]    ptr,
  input  logic [LANES-1:0] req,
  output logic             valid,
  output logic [LW-1:0]    sel
);

  logic [2*LANES-1:0] dbl;
  logic [LANES-1:0]   rot;
  logic [LW-1:0]      off;

  assign dbl = {req, req};
  assign rot = dbl[ptr +: LANES];
  assign valid = |rot;
  assign sel = ptr + off;

  always_comb begin
    off = '0;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      rot[3]:  off = 2'd3;
      default: off = 2'd0;
    endcase
  end

endmodule

// File: rtl/lane_phase_scheduler.sv
// Intersection phase sequencer: round-robin green service,
// yellow and all-red clearance, emergency preemption.
module lane_phase_scheduler
  import tlfs_pkg::*;
#(
  parameter int MAX_GREEN = 5,
  parameter int MIN_GREEN = 2,
  parameter int YEL_T     = 2,
  parameter int RED_T     = 1,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst,
  lane_phase_scheduler_if.slave bus
);

  localparam int TMAX =
    (MAX_GREEN > YEL_T)
      ? ((MAX_GREEN > RED_T) ? MAX_GREEN : RED_T)
      : ((YEL_T > RED_T) ? YEL_T : RED_T);
  localparam int TW = $clog2(TMAX + 1);

  state_t           state, state_n;
  logic [TW-1:0]    timer, timer_n, timer_inc;
  logic [LW-1:0]    lane_q, lane_n;
  logic [LW-1:0]    ptr, ptr_n;
  logic             pre_q, pre_n;
  logic [LANES-1:0] green_q, yellow_q, red_q;
  logic [LANES-1:0] green_n, yellow_n;
  logic [LANES-1:0] nz;
  logic             cur_v, emg_v;
  logic [LW-1:0]    cur_sel, emg_sel;
  logic             any_emg, own_emg;
  int               tn;

  assign nz = {bus.cur4 != CNT_W'(0), bus.cur3 != CNT_W'(0),
               bus.cur2 != CNT_W'(0), bus.cur1 != CNT_W'(0)};
  assign any_emg = |bus.emg;
  assign own_emg = bus.emg[lane_q];
  assign timer_inc = (timer == '1) ? timer : timer + TW'(1);
  assign tn = int'(timer) + 1;

  rr_lane_pick u_cur (
    .ptr   (ptr),
    .req   (nz),
    .valid (cur_v),
    .sel   (cur_sel)
  );

  // Fixed pointer 0 turns the picker into a lowest-index priority pick.
  rr_lane_pick u_emg (
    .ptr   (2'd0),
    .req   (bus.emg),
    .valid (emg_v),
    .sel   (emg_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ALLRED;
      timer    <= '0;
      lane_q   <= '0;
      ptr      <= '0;
      pre_q    <= 1'b0;
      green_q  <= '0;
      yellow_q <= '0;
      red_q    <= '1;
    end else if (bus.en) begin
      state    <= state_n;
      timer    <= timer_n;
      lane_q   <= lane_n;
      ptr      <= ptr_n;
      pre_q    <= pre_n;
      green_q  <= green_n;
      yellow_q <= yellow_n;
      red_q    <= ~(green_n | yellow_n);
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    lane_n  = lane_q;
    ptr_n   = ptr;
    pre_n   = pre_q;
    if (bus.tick) begin
      unique case (state)
        ALLRED: begin
          if (int'(timer) >= RED_T) begin
            if (emg_v) begin
              state_n = EMG_GREEN;
              lane_n  = emg_sel;
              timer_n = '0;
              pre_n   = 1'b1;
            end else if (cur_v) begin
              state_n = GREEN;
              lane_n  = cur_sel;
              timer_n = '0;
              pre_n   = 1'b0;
            end else begin
              timer_n = timer_inc;
              pre_n   = 1'b0;
            end
          end else begin
            timer_n = timer_inc;
          end
        end
        GREEN: begin
          // Own-lane emergency freezes the green timer.
          if (!own_emg) begin
            if (tn == MAX_GREEN || any_emg ||
                (!nz[lane_q] && tn >= MIN_GREEN)) begin
              state_n = YELLOW;
              timer_n = '0;
              ptr_n   = lane_q + LW'(1);
              pre_n   = any_emg;
            end else begin
              timer_n = timer_inc;
            end
          end
        end
        YELLOW: begin
          if (tn == YEL_T) begin
            state_n = ALLRED;
            timer_n = '0;
          end else begin
            timer_n = timer_inc;
          end
        end
        EMG_GREEN: begin
          if (!own_emg) begin
            state_n = YELLOW;
            timer_n = '0;
            ptr_n   = lane_q + LW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    green_n  = '0;
    yellow_n = '0;
    unique case (state_n)
      GREEN, EMG_GREEN: green_n  = lane_onehot(lane_n);
      YELLOW:           yellow_n = lane_onehot(lane_n);
      ALLRED:           ;
    endcase
  end

  assign bus.green   = green_q;
  assign bus.yellow  = yellow_q;
  assign bus.red     = red_q;
  assign bus.lane    = lane_q;
  assign bus.preempt = pre_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(|green_q && |yellow_q) &&
              $onehot0(green_q) && $onehot0(yellow_q))
        else $error("green/yellow exclusivity violated");
    end
  end

endmodule

// File: tb/tb_lane_phase_scheduler.sv
// Scoreboard bench for lane_phase_scheduler: directed scenarios
// plus randomized traffic against a tick-level reference model.
module tb_lane_phase_scheduler;

  localparam int MAX_GREEN = 5;
  localparam int MIN_GREEN = 2;
  localparam int YEL_T     = 2;
  localparam int RED_T     = 1;

  localparam int AR_P = 0;
  localparam int G_P  = 1;
  localparam int Y_P  = 2;
  localparam int EG_P = 3;

  logic clk;
  logic rst;

  lane_phase_scheduler_if bus ();

  lane_phase_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] c [4];
  logic [3:0] m;

  int m_ph, m_cnt, m_ln, m_ptr;
  bit m_pre;

  logic [14:0] exp_q [$];
  string       nm_q  [$];
  int vectors;
  int miscompares;

  function automatic void enter(int p, int l);
    m_ph  = p;
    m_ln  = l;
    m_cnt = 0;
  endfunction

  // Phase/elapsed-tick reference, one call per clock.
  function automatic void model_step(bit r, bit e, bit t);
    int nxt;
    if (r) begin
      m_ph = AR_P; m_cnt = 0; m_ln = 0; m_ptr = 0; m_pre = 0;
      return;
    end
    if (!(e && t)) return;
    case (m_ph)
      AR_P: begin
        if (m_cnt >= RED_T) begin
          if (m != 0) begin
            nxt = 0;
            for (int k = 3; k >= 0; k--) if (m[k]) nxt = k;
            enter(EG_P, nxt);
            m_pre = 1;
          end else begin
            nxt = -1;
            for (int k = 3; k >= 0; k--)
              if (c[(m_ptr + k) % 4] != 0) nxt = (m_ptr + k) % 4;
            m_pre = 0;
            if (nxt >= 0) enter(G_P, nxt);
            else m_cnt++;
          end
        end else m_cnt++;
      end
      G_P: begin
        if (!m[m_ln]) begin
          if (m_cnt + 1 == MAX_GREEN || m != 0 ||
              (c[m_ln] == 0 && m_cnt + 1 >= MIN_GREEN)) begin
            m_pre = (m != 0);
            m_ptr = (m_ln + 1) % 4;
            enter(Y_P, m_ln);
          end else m_cnt++;
        end
      end
      Y_P: begin
        if (m_cnt + 1 == YEL_T) enter(AR_P, m_ln);
        else m_cnt++;
      end
      default: begin
        if (!m[m_ln]) begin
          m_ptr = (m_ln + 1) % 4;
          enter(Y_P, m_ln);
        end
      end
    endcase
  endfunction

  function automatic logic [14:0] model_out();
    logic [3:0] g, y;
    g = 4'd0;
    y = 4'd0;
    if (m_ph == G_P || m_ph == EG_P) g[m_ln] = 1'b1;
    if (m_ph == Y_P) y[m_ln] = 1'b1;
    return {g, y, ~(g | y), 2'(m_ln), m_pre};
  endfunction

  task automatic step(input bit r, input bit e, input bit t,
                      input string nm);
    @(negedge clk);
    rst = r;
    bus.en = e;
    bus.tick = t;
    bus.cur1 = c[0];
    bus.cur2 = c[1];
    bus.cur3 = c[2];
    bus.cur4 = c[3];
    bus.emg = m;
    model_step(r, e, t);
    exp_q.push_back(model_out());
    nm_q.push_back(nm);
  endtask

  task automatic run_ticks(input int n, input string nm);
    for (int i = 0; i < n * 4; i++) step(0, 1, (i % 4) == 0, nm);
  endtask

  task automatic do_reset(input string nm);
    step(1, 1, 0, nm);
    step(1, 1, 1, nm);
  endtask

  task automatic set_cur(input int a, input int b,
                         input int d, input int f);
    c[0] = 4'(a); c[1] = 4'(b); c[2] = 4'(d); c[3] = 4'(f);
  endtask

  always @(posedge clk) begin
    logic [14:0] e, got;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      got = {bus.green, bus.yellow, bus.red, bus.lane, bus.preempt};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL %s @%0t: got g=%b y=%b r=%b lane=%0d pre=%b want g=%b y=%b r=%b lane=%0d pre=%b",
                 nm, $time, got[14:11], got[10:7], got[6:3], got[2:1], got[0],
                 e[14:11], e[10:7], e[6:3], e[2:1], e[0]);
      end
    end
  end

  initial begin
    int freeze;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.tick = 1'b0;
    m = 4'd0;
    set_cur(0, 0, 0, 0);
    bus.cur1 = '0; bus.cur2 = '0; bus.cur3 = '0; bus.cur4 = '0;
    bus.emg = '0;

    do_reset("reset");

    set_cur(3, 0, 2, 0);
    run_ticks(24, "rr_basic");

    do_reset("reset2");
    set_cur(3, 0, 0, 0);
    run_ticks(3, "min_green_pre");
    c[0] = 4'd0;
    run_ticks(6, "min_green");

    do_reset("reset3");
    set_cur(3, 0, 0, 0);
    run_ticks(5, "late_drop_pre");
    c[0] = 4'd0;
    run_ticks(5, "late_drop");

    do_reset("reset4");
    set_cur(3, 0, 2, 5);
    run_ticks(3, "preempt_pre");
    m = 4'b0100;
    run_ticks(16, "preempt_hold");
    m = 4'b0000;
    run_ticks(12, "preempt_release");

    do_reset("reset5");
    set_cur(3, 0, 0, 0);
    run_ticks(4, "own_emg_pre");
    m = 4'b0001;
    run_ticks(8, "own_emg_hold");
    m = 4'b0000;
    run_ticks(8, "own_emg_release");

    do_reset("reset6");
    set_cur(0, 0, 0, 0);
    run_ticks(8, "idle");
    c[1] = 4'd1;
    run_ticks(6, "idle_wake");

    do_reset("reset7");
    set_cur(3, 0, 0, 0);
    run_ticks(8, "to_yellow");
    step(0, 1, 1, "mid_yellow");
    step(1, 1, 1, "rst_mid_yellow");
    run_ticks(3, "after_rst");

    do_reset("reset8");
    set_cur(3, 0, 0, 0);
    run_ticks(4, "freeze_pre");
    for (int i = 0; i < 20; i++) step(0, 0, (i % 3) == 0, "freeze");
    run_ticks(6, "freeze_post");

    freeze = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 14) == 0)
        for (int k = 0; k < 4; k++)
          c[k] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 3))
          0, 1: m = 4'd0;
          2: m = 4'd1 << $urandom_range(0, 3);
          default: m = 4'($urandom_range(0, 15));
        endcase
      end
      if (freeze == 0 && $urandom_range(0, 30) == 0)
        freeze = $urandom_range(1, 10);
      step($urandom_range(0, 299) == 0, freeze == 0,
           $urandom_range(0, 2) == 0, "random");
      if (freeze > 0) freeze--;
    end

    repeat (4) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected outputs never checked, want 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
